pixel_window_buffer: RTL and testbench

PIXEL_WINDOW_BUFFER -- requirements
Module: pixel_window_buffer

---
 rtl/pixel_window_buffer.sv | 111 +++++++++++
 tb/tb_pixel_window_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_buffer.sv
// pixel_window_buffer: 3x3 sliding window over a raster-order RGB332 stream.
// Define SOF_RESYNC_EN to add the frame_start resync input.
module pixel_window_buffer #(
  parameter int IMAGE_WIDTH  = 160,
  parameter int IMAGE_HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
`ifdef SOF_RESYNC_EN
  input  logic        frame_start,
`endif
  output logic [71:0] window_out,
  output logic        window_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row;
  logic [RW-1:0] row_eff;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          in_win;

  logic [7:0]    line_a [IMAGE_WIDTH];
  logic [7:0]    line_b [IMAGE_WIDTH];
  logic [7:0]    tap_a;
  logic [7:0]    tap_b;

  logic [23:0]   win_top;
  logic [23:0]   win_mid;
  logic [23:0]   win_bot;

`ifdef SOF_RESYNC_EN
  assign sof = frame_start;
`else
  assign sof = 1'b0;
`endif

  // A resync pixel is treated as (0,0) in the same cycle.
  assign col_eff = sof ? '0 : col;
  assign row_eff = sof ? '0 : row;

  assign eol    = (col_eff == COL_LAST);
  assign eof    = eol && (row_eff == ROW_LAST);
  assign in_win = (col_eff >= COL_TWO) && (row_eff >= ROW_TWO);

  assign tap_a = line_a[col_eff];
  assign tap_b = line_b[col_eff];

  // Line buffers are left unreset; row gating hides stale data.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      line_b[col_eff] <= tap_a;
      line_a[col_eff] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      win_top      <= '0;
      win_mid      <= '0;
      win_bot      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (sof) begin
        col <= '0;
        row <= '0;
      end
      if (pixel_valid) begin
        win_top      <= {win_top[15:0], tap_b};
        win_mid      <= {win_mid[15:0], tap_a};
        win_bot      <= {win_bot[15:0], pixel_in};
        window_valid <= in_win;
        frame_done   <= in_win && eof;
        unique case (1'b1)
          eof: begin
            col <= '0;
            row <= '0;
          end
          eol && !eof: begin
            col <= '0;
            row <= row_eff + RW'(1);
          end
          default: begin
            col <= col_eff + CW'(1);
            row <= row_eff;
          end
        endcase
      end
    end
  end

  assign window_out = {win_top, win_mid, win_bot};

endmodule

// File: tb/tb_pixel_window_buffer.sv
// tb_pixel_window_buffer: frame-image reference model vs pixel_window_buffer.
// Directed raster frames, idle gaps, mid-frame reset and randomized frames.
module tb_pixel_window_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  pixel_in = 8'h00;
  logic        pixel_valid = 1'b0;
`ifdef SOF_RESYNC_EN
  logic        frame_start = 1'b0;
`endif
  logic [71:0] window_out;
  logic        window_valid;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  img [H][W];
  int          mrow;
  int          mcol;
  bit          known;
  logic [71:0] mwin;
  int          nvalid;
  int          ndone;
  logic [71:0] first_win;
  logic [71:0] last_win;
  bit          last_done;

  always #5 clk = ~clk;

  pixel_window_buffer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
`ifdef SOF_RESYNC_EN
    .frame_start (frame_start),
`endif
    .window_out  (window_out),
    .window_valid(window_valid),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] p, input bit sof);
    bit ev;
    bit ed;
    ev = 1'b0;
    ed = 1'b0;
    if (sof) begin
      mrow = 0;
      mcol = 0;
    end
    if (v) begin
      img[mrow][mcol] = p;
      ev = (mrow >= 2) && (mcol >= 2);
      ed = (mrow == H - 1) && (mcol == W - 1);
      if (ev) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            mwin[71 - 8 * (3 * i + j) -: 8] = img[mrow - 2 + i][mcol - 2 + j];
      end
      known = ev;
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow++;
        if (mrow == H) mrow = 0;
      end
    end
    @(negedge clk);
    pixel_valid = v;
    pixel_in    = p;
`ifdef SOF_RESYNC_EN
    frame_start = sof;
`endif
    @(posedge clk);
    #1;
    check("window_valid", {71'd0, window_valid}, {71'd0, ev});
    check("frame_done", {71'd0, frame_done}, {71'd0, ed});
    if (known) check("window_out", window_out, mwin);
    if (window_valid) begin
      if (nvalid == 0) first_win = window_out;
      nvalid++;
      last_win  = window_out;
      last_done = frame_done;
    end
    if (frame_done) ndone++;
  endtask

  task automatic send_frame(input int gap, input bit rnd);
    logic [7:0] p;
    int g;
    for (int k = 0; k < W * H; k++) begin
      p = rnd ? 8'($urandom) : 8'(k);
      step(1'b1, p, 1'b0);
      g = rnd ? int'($urandom_range(0, 3)) : gap;
      for (int q = 0; q < g; q++) step(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    pixel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_window", window_out, 72'd0);
    check("rst_valid", {71'd0, window_valid}, 72'd0);
    check("rst_done", {71'd0, frame_done}, 72'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_window", window_out, 72'd0);
    rst_n = 1'b1;
    mrow  = 0;
    mcol  = 0;
    known = 1'b1;
    mwin  = '0;
  endtask

  task automatic clear_stats();
    nvalid    = 0;
    ndone     = 0;
    first_win = '0;
    last_win  = '0;
    last_done = 1'b0;
  endtask

  initial begin
    mrow = 0;
    mcol = 0;
    known = 1'b0;
    mwin = '0;
    clear_stats();
    #3;
    do_reset();

    // back-to-back frame of pixel n = n
    clear_stats();
    send_frame(0, 1'b0);
    check("f1_nvalid", 72'(nvalid), 72'd4);
    check("f1_first", first_win, 72'h000102_040506_08090A);
    check("f1_last", last_win, 72'h050607_090A0B_0D0E0F);
    check("f1_last_done", {71'd0, last_done}, 72'd1);
    check("f1_ndone", 72'(ndone), 72'd1);

    clear_stats();
    send_frame(0, 1'b0);
    check("f2_nvalid", 72'(nvalid), 72'd4);
    check("f2_first", first_win, 72'h000102_040506_08090A);
    check("f2_last", last_win, 72'h050607_090A0B_0D0E0F);

    // three idle cycles after every pixel
    clear_stats();
    send_frame(3, 1'b0);
    check("gap_nvalid", 72'(nvalid), 72'd4);
    check("gap_first", first_win, 72'h000102_040506_08090A);
    check("gap_last", last_win, 72'h050607_090A0B_0D0E0F);

    // reset in mid-frame after pixel 0x06
    for (int k = 0; k < 7; k++) step(1'b1, 8'(k + 8'h40), 1'b0);
    do_reset();
    clear_stats();
    send_frame(0, 1'b0);
    check("rst_first", first_win, 72'h000102_040506_08090A);
    check("rst_nvalid", 72'(nvalid), 72'd4);

    // randomized pixels and gaps
    for (int f = 0; f < 6; f++) begin
      clear_stats();
      send_frame(0, 1'b1);
      check("rnd_nvalid", 72'(nvalid), 72'd4);
      check("rnd_ndone", 72'(ndone), 72'd1);
    end

`ifdef SOF_RESYNC_EN
    for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 1'b0);
    clear_stats();
    for (int k = 0; k < W * H; k++) begin
      step(1'b1, 8'(k), k == 0);
      if (k == 9) check("sof_early", 72'(nvalid), 72'd0);
    end
    check("sof_nvalid", 72'(nvalid), 72'd4);
    check("sof_first", first_win, 72'h000102_040506_08090A);
    for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    clear_stats();
    send_frame(0, 1'b0);
    check("sof_idle_first", first_win, 72'h000102_040506_08090A);
`endif

    repeat (2) step(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
